// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - two-button operand entry: sync + debounce buttons, 4-state load FSM.
// Buttons are conditioned into one-cycle press pulses which step A/B capture and the sum select.

module operand_loader_btn #(
  parameter int DEB_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   level;
  logic [CW-1:0]          cnt;
  logic                   cnt_done;

  assign synced   = sync[SYNC_STAGES-1];
  assign cnt_done = (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // The press pulse is registered together with the level change, so it is
  // high exactly in the first cycle the debounced level reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt_done) begin
        level <= synced;
        cnt   <= '0;
        press <= synced;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module operand_loader #(
  parameter int DEB_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] SW,
  input  logic       BTN_NEXT,
  input  logic       BTN_CLR,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       START,
  output logic [1:0] STATE,
  output logic       SUM_VALID
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    HAVE_B = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t state;
  logic   next_ev;
  logic   clr_ev;

  operand_loader_btn #(
    .DEB_CYCLES (DEB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_next (
    .clk  (CLK),
    .rst_n(RST_N),
    .raw  (BTN_NEXT),
    .press(next_ev)
  );

  operand_loader_btn #(
    .DEB_CYCLES (DEB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_clr (
    .clk  (CLK),
    .rst_n(RST_N),
    .raw  (BTN_CLR),
    .press(clr_ev)
  );

  assign STATE = state;

  // Clear wins over a coincident advance; SW is only looked at on a capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      A         <= 3'b000;
      B         <= 3'b000;
      START     <= 1'b0;
      SUM_VALID <= 1'b0;
    end else begin
      SUM_VALID <= 1'b0;
      if (clr_ev) begin
        state <= IDLE;
        A     <= 3'b000;
        B     <= 3'b000;
        START <= 1'b0;
      end else if (next_ev) begin
        case (state)
          IDLE: begin
            A     <= SW;
            state <= HAVE_A;
          end
          HAVE_A: begin
            B     <= SW;
            state <= HAVE_B;
          end
          HAVE_B: begin
            START     <= 1'b1;
            SUM_VALID <= 1'b1;
            state     <= SHOW;
          end
          default: begin
            A     <= 3'b000;
            B     <= 3'b000;
            START <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - table-driven and directed checks of operand_loader.

module tb_operand_loader;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] SW;
  logic       BTN_NEXT;
  logic       BTN_CLR;
  logic [2:0] A;
  logic [2:0] B;
  logic       START;
  logic [1:0] STATE;
  logic       SUM_VALID;

  operand_loader #(
    .DEB_CYCLES (4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .SW       (SW),
    .BTN_NEXT (BTN_NEXT),
    .BTN_CLR  (BTN_CLR),
    .A        (A),
    .B        (B),
    .START    (START),
    .STATE    (STATE),
    .SUM_VALID(SUM_VALID)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int         sv_count   = 0;
  int         sv_run     = 0;
  int         sv_long    = 0;
  int         trans      = 0;
  int         start_bad  = 0;
  logic [1:0] prev_state = 2'b00;

  always @(negedge CLK) begin
    if (SUM_VALID === 1'b1) begin
      sv_count++;
      sv_run++;
      if (sv_run > 1) sv_long++;
    end else begin
      sv_run = 0;
    end
    if (STATE !== prev_state) trans++;
    prev_state = STATE;
    if (RST_N === 1'b1 && START !== (STATE == 2'b11)) start_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic nxt, input logic clr, input int hold);
    BTN_NEXT = nxt;
    BTN_CLR  = clr;
    cycles(hold);
    BTN_NEXT = 1'b0;
    BTN_CLR  = 1'b0;
    cycles(12);
  endtask

  typedef struct {
    logic [1:0] op;     // 0 none, 1 next, 2 clr
    logic [2:0] sw;
    logic [2:0] a;
    logic [2:0] b;
    logic       start;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[10];
  int   sv0;
  int   tr0;

  initial begin
    vecs[0] = '{2'd1, 3'd3, 3'd3, 3'd0, 1'b0, 2'b01};
    vecs[1] = '{2'd0, 3'd7, 3'd3, 3'd0, 1'b0, 2'b01};
    vecs[2] = '{2'd1, 3'd5, 3'd3, 3'd5, 1'b0, 2'b10};
    vecs[3] = '{2'd1, 3'd7, 3'd3, 3'd5, 1'b1, 2'b11};
    vecs[4] = '{2'd1, 3'd1, 3'd0, 3'd0, 1'b0, 2'b00};
    vecs[5] = '{2'd1, 3'd6, 3'd6, 3'd0, 1'b0, 2'b01};
    vecs[6] = '{2'd2, 3'd2, 3'd0, 3'd0, 1'b0, 2'b00};
    vecs[7] = '{2'd1, 3'd7, 3'd7, 3'd0, 1'b0, 2'b01};
    vecs[8] = '{2'd1, 3'd0, 3'd7, 3'd0, 1'b0, 2'b10};
    vecs[9] = '{2'd2, 3'd4, 3'd0, 3'd0, 1'b0, 2'b00};

    RST_N    = 1'b0;
    SW       = 3'd0;
    BTN_NEXT = 1'b0;
    BTN_CLR  = 1'b0;
    cycles(3);
    check("rst_a", A, 0);
    check("rst_b", B, 0);
    check("rst_start", START, 0);
    check("rst_state", STATE, 0);
    check("rst_sv", SUM_VALID, 0);
    RST_N = 1'b1;
    cycles(4);

    sv0 = sv_count;
    for (int i = 0; i < 10; i++) begin
      SW = vecs[i].sw;
      if (vecs[i].op == 2'd1) press(1'b1, 1'b0, 12);
      else if (vecs[i].op == 2'd2) press(1'b0, 1'b1, 12);
      else cycles(20);
      check($sformatf("vec%0d_a", i), A, vecs[i].a);
      check($sformatf("vec%0d_b", i), B, vecs[i].b);
      check($sformatf("vec%0d_start", i), START, vecs[i].start);
      check($sformatf("vec%0d_state", i), STATE, vecs[i].state);
    end
    check("table_sv_pulses", sv_count - sv0, 1);

    // Bounce: 2-cycle high/low toggling must not debounce; the final hold does.
    SW  = 3'd2;
    tr0 = trans;
    for (int i = 0; i < 5; i++) begin
      BTN_NEXT = 1'b1;
      cycles(2);
      BTN_NEXT = 1'b0;
      cycles(2);
    end
    check("bounce_no_event", trans - tr0, 0);
    press(1'b1, 1'b0, 12);
    check("bounce_trans", trans - tr0, 1);
    check("bounce_a", A, 2);
    check("bounce_state", STATE, 1);

    // Clear priority from HAVE_B.
    SW = 3'd4;
    press(1'b1, 1'b0, 12);
    check("pre_clr_state", STATE, 2);
    check("pre_clr_b", B, 4);
    sv0 = sv_count;
    press(1'b1, 1'b1, 12);
    check("clrpri_state", STATE, 0);
    check("clrpri_start", START, 0);
    check("clrpri_sv", sv_count - sv0, 0);

    // Held button: one transition only.
    SW  = 3'd1;
    tr0 = trans;
    press(1'b1, 1'b0, 100);
    check("held_trans", trans - tr0, 1);
    check("held_state", STATE, 1);
    check("held_a", A, 1);

    // Reset mid-sequence in HAVE_A with A=6.
    press(1'b0, 1'b1, 12);
    SW = 3'd6;
    press(1'b1, 1'b0, 12);
    check("prerst_a", A, 6);
    #3;
    RST_N = 1'b0;
    #1;
    check("async_rst_a", A, 0);
    check("async_rst_state", STATE, 0);
    cycles(3);
    RST_N = 1'b1;
    cycles(4);
    sv0 = sv_count;
    SW = 3'd3;
    press(1'b1, 1'b0, 12);
    SW = 3'd5;
    press(1'b1, 1'b0, 12);
    press(1'b1, 1'b0, 12);
    check("post_rst_a", A, 3);
    check("post_rst_b", B, 5);
    check("post_rst_start", START, 1);
    check("post_rst_state", STATE, 3);
    check("post_rst_sv", sv_count - sv0, 1);

    // Wrap from SHOW.
    press(1'b1, 1'b0, 12);
    check("wrap_a", A, 0);
    check("wrap_b", B, 0);
    check("wrap_start", START, 0);
    check("wrap_state", STATE, 0);

    check("sv_single_cycle", sv_long, 0);
    check("start_only_in_show", start_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
